led7_scan_reader: RTL
=====================

Name: led7_scan_reader

Overview:
- Reads a multiplexed, active-low 7-segment display bus: a digit-select (anode) vector plus a shared segment bus.
- Recovers the hex value shown on each digit and holds all digits in a register bank.
- Inverse of the team's binary-to-7-segment decoder path.
- Used as a display-loopback monitor in the door-lock top level and as a self-check block in the display testbench.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (≥1).
- STABLE_CYCLES, 4, consecutive identical clock samples of the (anode, segment) pair required before a commit (≥2).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_en  input  1  enable; low suppresses commits.
- i_anode  input  NUM_DIGITS  digit select, active-low; bit k low selects digit k.
- i_7seg  input  7  segments, active-low, bit6=g ... bit0=a.
- o_digits  output  4*NUM_DIGITS  recovered nibbles; digit k at [4k+3:4k].
- o_blank  output  NUM_DIGITS  bit k = 1 when digit k last showed all segments off.
- o_index  output  clog2(NUM_DIGITS), min 1  digit index of the most recent commit.
- o_valid  output  1  one-cycle pulse on each successful commit.
- o_err  output  1  one-cycle pulse on each commit of an illegal segment pattern.

Behaviour:
- Async reset (i_rst_n=0), immediate:
  - Outputs: o_digits=0, o_blank=all 1, o_index=0, o_valid=0, o_err=0.
  - Internal: prev_anode=all 1, prev_seg=7'h7F, cnt=0, done=0.
- Stability tracker, each rising edge:
  - Input pair ≠ (prev_anode, prev_seg): load prev with the input pair, cnt←1, done←0.
  - Pair equal and cnt<STABLE_CYCLES: cnt←cnt+1.
  - cnt saturates at STABLE_CYCLES.
- Commit condition, at the edge where:
  - pair equal,
  - cnt==STABLE_CYCLES-1,
  - done==0,
  - i_en==1.
- On commit, set done←1; at most one commit per stable hold, however long the hold lasts.
- Latency: a pair first present before edge n commits at edge n+STABLE_CYCLES-1. Outputs are registered and visible after that edge.
- Anode qualification:
  - Commit acts only if exactly one i_anode bit is 0.
  - Zero or multiple low bits (blanking or ghosting): done←1 and no output changes, no pulses.
- Segment decode, standard active-low hex font:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000.
  - 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110.
- Commit results:
  - Legal pattern: digit k nibble←value, o_blank[k]←0, o_index←k, o_valid=1 for one cycle.
  - 7'h7F: nibble unchanged, o_blank[k]←1, o_index←k, o_valid=1.
  - Any other pattern: digit state unchanged, o_index←k, o_err=1 for one cycle, o_valid=0.
- i_en=0:
  - Tracker keeps running; commits are blocked.
  - If i_en rises while cnt is saturated and done==0, no commit occurs. The pair must change and re-stabilise.
- Simultaneous anode and segment change counts as a single change; cnt←1.
- Async reset mid-hold discards the partial count. After release, the pair needs a full STABLE_CYCLES hold.
- o_valid and o_err are never high in the same cycle.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle -> outputs go to reset values immediately, no clock needed. With NUM_DIGITS=4: o_digits=16'h0000, o_blank=4'hF.
- Legal commit: i_en=1, i_anode=4'b1110, i_7seg=7'b0010010 held 10 cycles -> exactly one o_valid pulse, on the 4th edge. Then o_digits[3:0]=5, o_blank[0]=0, o_index=0.
- Glitch rejection: pair held 3 edges, then segments change -> no o_valid. The new pair held 4 edges -> commits the new value.
- Illegal and blank patterns:
  - i_anode=4'b1011, i_7seg=7'b0111111 held 4 edges -> o_err pulse, o_index=2, o_digits unchanged.
  - Then 7'b1111111 -> o_valid pulse, o_blank[2]=1.
- Full scan: digits 0..3 show 1,2,3,4 (4 cycles each), with all-high anode gaps and a two-low-anode ghost pattern between them -> o_digits=16'h4321, o_blank=4'h0, 4 o_valid pulses, no o_err.
- Enable and reset interplay:
  - i_en=0 during a full hold -> no commit.
  - Reset pulsed at cnt=3 -> no commit until a fresh 4-edge hold completes.

Source files
------------

// File: rtl/led7_scan_reader.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the hex value
// shown on each digit once its (anode, segment) pair has been stable long enough.
module led7_scan_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  localparam int unsigned IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [NUM_DIGITS-1:0]   i_anode,
  input  logic [6:0]              i_7seg,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic [IDX_W-1:0]        o_index,
  output logic                    o_valid,
  output logic                    o_err
);

  localparam int unsigned CNT_W     = $clog2(STABLE_CYCLES + 1);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Tracker and output state plus their next-state values.
  logic [NUM_DIGITS-1:0]   prev_anode, prev_anode_n;
  logic [6:0]              prev_seg, prev_seg_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    done, done_n;
  logic [4*NUM_DIGITS-1:0] digits, digits_n;
  logic [NUM_DIGITS-1:0]   blank, blank_n;
  logic [IDX_W-1:0]        index, index_n;
  logic                    valid, valid_n;
  logic                    err, err_n;

  logic                    pair_eq;
  logic                    commit;
  logic                    dec_legal;
  logic [3:0]              dec_val;
  logic                    one_low;
  logic [IDX_W-1:0]        sel_idx;
  int unsigned             low_cnt;

  // Active-low hex font lookup.
  always_comb begin
    dec_legal = 1'b1;
    dec_val   = 4'h0;
    case (i_7seg)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    dec_legal = 1'b0;
    endcase
  end

  // A commit is only meaningful when exactly one digit is selected.
  always_comb begin
    low_cnt = 0;
    sel_idx = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (!i_anode[k]) begin
        low_cnt = low_cnt + 1;
        sel_idx = IDX_W'(k);
      end
    end
    one_low = (low_cnt == 1);
  end

  assign pair_eq = (i_anode == prev_anode) && (i_7seg == prev_seg);
  assign commit  = pair_eq && (cnt == CNT_W'(STABLE_CYCLES - 1)) && !done && i_en;

  // Next-state: stability tracking and commit effects.
  always_comb begin
    prev_anode_n = prev_anode;
    prev_seg_n   = prev_seg;
    cnt_n        = cnt;
    done_n       = done;
    digits_n     = digits;
    blank_n      = blank;
    index_n      = index;
    valid_n      = 1'b0;
    err_n        = 1'b0;

    if (!pair_eq) begin
      prev_anode_n = i_anode;
      prev_seg_n   = i_7seg;
      cnt_n        = CNT_W'(1);
      done_n       = 1'b0;
    end else if (cnt < CNT_W'(STABLE_CYCLES)) begin
      cnt_n = cnt + CNT_W'(1);
    end

    if (commit) begin
      done_n = 1'b1;
      if (one_low) begin
        index_n = sel_idx;
        if (dec_legal) begin
          valid_n = 1'b1;
          for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (!i_anode[k]) begin
              digits_n[4*k +: 4] = dec_val;
              blank_n[k]         = 1'b0;
            end
          end
        end else if (i_7seg == SEG_BLANK) begin
          valid_n = 1'b1;
          for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (!i_anode[k]) blank_n[k] = 1'b1;
          end
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_anode <= '1;
      prev_seg   <= SEG_BLANK;
      cnt        <= '0;
      done       <= 1'b0;
      digits     <= '0;
      blank      <= '1;
      index      <= '0;
      valid      <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_anode <= prev_anode_n;
      prev_seg   <= prev_seg_n;
      cnt        <= cnt_n;
      done       <= done_n;
      digits     <= digits_n;
      blank      <= blank_n;
      index      <= index_n;
      valid      <= valid_n;
      err        <= err_n;
    end
  end

  assign o_digits = digits;
  assign o_blank  = blank;
  assign o_index  = index;
  assign o_valid  = valid;
  assign o_err    = err;

endmodule
